// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle load/store unit with sizing, extension, byte enables, ack handshake and timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return misalign_err instead of being force-aligned.
module riscv_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    stall,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    bus_err,
  output logic                    misalign_err,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] MAX_SZ = 2'(OW);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic a_write, a_uns, err_q, mis_q, accept, mis, done, acc, sgn;
  logic [1:0] a_sz, r_sz;
  logic [OW:0] nb;
  logic [OW-1:0] off;
  logic [ADDR_WIDTH-1:0] a_addr, r_mask;
  logic [DATA_WIDTH-1:0] a_wdata, rdata_q, sh, ext;
  logic [NB-1:0] be;
  always_comb begin
    accept = state == IDLE && req_valid;
    r_sz = (req_funct3[1:0] > MAX_SZ) ? MAX_SZ : req_funct3[1:0];
    r_mask = (ADDR_WIDTH'(1) << r_sz) - ADDR_WIDTH'(1);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = |(req_addr & r_mask);
`else
    mis = 1'b0;
`endif
    done = state == ACCESS && (mem_ack || cnt == CW'(MAX_WAIT));
    state_n = state == IDLE ? (req_valid ? (mis ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  end
  always_comb begin
    nb = (OW+1)'(1) << a_sz;
    off = a_addr[OW-1:0];
    sh = mem_rdata >> {off, 3'b000};
    sgn = !a_uns && (a_sz == 2'd0 ? sh[7] : a_sz == 2'd1 ? sh[15] : a_sz == 2'd2 ? sh[31] : sh[DATA_WIDTH-1]);
    ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) ext[i] = (i < 8 * int'(nb)) ? sh[i] : sgn;
    be = '0;
    for (int i = 0; i < NB; i++) be[i] = (i >= int'(off)) && (i < int'(off) + int'(nb));
  end
  always_comb begin
    acc = state == ACCESS;
    req_ready = state == IDLE;
    stall = accept || acc;
    mem_read_en = acc && !a_write;
    mem_write_en = acc && a_write;
    mem_addr = acc ? {a_addr[ADDR_WIDTH-1:OW], OW'(0)} : '0;
    mem_byte_en = acc ? be : '0;
    mem_wdata = acc ? a_wdata << {off, 3'b000} : '0;
    rsp_valid = state == RESP;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    bus_err = rsp_valid && err_q;
    misalign_err = rsp_valid && mis_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      a_write <= 1'b0;
      a_uns <= 1'b0;
      a_sz <= '0;
      a_addr <= '0;
      a_wdata <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_write <= req_write;
        a_uns <= req_funct3[2];
        a_sz <= r_sz;
        a_addr <= req_addr & ~r_mask;
        a_wdata <= req_wdata;
        cnt <= '0;
        rdata_q <= '0;
        err_q <= 1'b0;
        mis_q <= mis;
      end
      // ack has priority over the timeout in the final wait cycle
      if (acc) begin
        if (mem_ack) rdata_q <= a_write ? '0 : ext;
        else begin
          cnt <= cnt + CW'(1);
          err_q <= done;
        end
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed checks of riscv_lsu at 32-bit and 64-bit data widths.
module tb_riscv_lsu;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic sel = 1'b0, req_valid = 1'b0, req_write = 1'b0, mem_ack = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [8:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;
  logic v32, v64;
  logic rdy32, st32, rv32, be32, mi32, re32, we32;
  logic rdy64, st64, rv64, be64, mi64, re64, we64;
  logic [31:0] rd32, wd32;
  logic [63:0] rd64, wd64;
  logic [8:0] ma32, ma64;
  logic [3:0] mbe32;
  logic [7:0] mbe64;
  logic o_rdy, o_stall, o_rv, o_berr, o_mis, o_re, o_we;
  logic [63:0] o_rd, o_wd;
  logic [8:0] o_ma;
  logic [7:0] o_be;
  assign v32 = req_valid && !sel;
  assign v64 = req_valid && sel;
  assign o_rdy = sel ? rdy64 : rdy32;
  assign o_stall = sel ? st64 : st32;
  assign o_rv = sel ? rv64 : rv32;
  assign o_berr = sel ? be64 : be32;
  assign o_mis = sel ? mi64 : mi32;
  assign o_re = sel ? re64 : re32;
  assign o_we = sel ? we64 : we32;
  assign o_rd = sel ? rd64 : {32'b0, rd32};
  assign o_wd = sel ? wd64 : {32'b0, wd32};
  assign o_ma = sel ? ma64 : ma32;
  assign o_be = sel ? mbe64 : {4'b0, mbe32};
  riscv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MAX_WAIT(15)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .stall(st32),
    .rsp_valid(rv32), .rsp_rdata(rd32), .bus_err(be32), .misalign_err(mi32),
    .mem_read_en(re32), .mem_write_en(we32), .mem_addr(ma32), .mem_byte_en(mbe32),
    .mem_wdata(wd32), .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack));
  riscv_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .MAX_WAIT(15)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .stall(st64),
    .rsp_valid(rv64), .rsp_rdata(rd64), .bus_err(be64), .misalign_err(mi64),
    .mem_read_en(re64), .mem_write_en(we64), .mem_addr(ma64), .mem_byte_en(mbe64),
    .mem_wdata(wd64), .mem_rdata(mem_rdata), .mem_ack(mem_ack));
  int checks = 0, errors = 0;
  int res_cycle, stall_cnt;
  logic saw_en, cap_re, cap_we, res_berr, res_mis;
  logic [8:0] cap_ma;
  logic [7:0] cap_be;
  logic [63:0] cap_wd, res_rd;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // cycle 0 is the accept cycle; outputs sampled 1 time unit after each negedge
  task automatic run(input logic w, input logic [2:0] f3, input logic [8:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input int ack_at);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = rd; mem_ack = 1'b0;
    res_cycle = -1; stall_cnt = 0; saw_en = 1'b0; cap_re = 1'b0; cap_we = 1'b0;
    cap_ma = '0; cap_be = '0; cap_wd = '0; res_rd = '0; res_berr = 1'b0; res_mis = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mem_ack = (c == ack_at);
      #1;
      if (o_stall) stall_cnt++;
      if (o_re || o_we) saw_en = 1'b1;
      if (c == 1) begin
        cap_re = o_re; cap_we = o_we; cap_ma = o_ma; cap_be = o_be; cap_wd = o_wd;
      end
      if (o_rv) begin
        res_cycle = c; res_rd = o_rd; res_berr = o_berr; res_mis = o_mis;
        break;
      end
      @(negedge clk);
      req_valid = 1'b0; req_write = !w; req_funct3 = ~f3; req_addr = ~a; req_wdata = ~wd;
    end
    mem_ack = 1'b0;
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready32", rdy32, 1'b1);
    chk("rst_ready64", rdy64, 1'b1);
    chk("rst_outs32", {st32, rv32, be32, mi32, re32, we32, ma32, mbe32, wd32, rd32}, '0);
    chk("rst_outs64", {st64, rv64, be64, mi64, re64, we64, ma64, mbe64, wd64, rd64}, '0);
    rst = 1'b1;
    run(1'b0, 3'b000, 9'h13, 64'h0, 64'h8081_8283, 1);
    chk("lb_cycle", res_cycle, 2);
    chk("lb_be", cap_be, 8'b1000);
    chk("lb_addr", cap_ma, 9'h10);
    chk("lb_re", {cap_re, cap_we}, 2'b10);
    chk("lb_rdata", res_rd, 64'hFFFF_FF80);
    chk("lb_berr", res_berr, 1'b0);
    run(1'b0, 3'b100, 9'h13, 64'h0, 64'h8081_8283, 1);
    chk("lbu_rdata", res_rd, 64'h80);
    run(1'b1, 3'b001, 9'h06, 64'h0000_BEEF, 64'h0, 1);
    chk("sh_we", {cap_re, cap_we}, 2'b01);
    chk("sh_addr", cap_ma, 9'h04);
    chk("sh_be", cap_be, 8'b1100);
    chk("sh_wdata", cap_wd, 64'hBEEF_0000);
    chk("sh_rdata", res_rd, 64'h0);
    run(1'b1, 3'b000, 9'h01, 64'hAB, 64'h0, 1);
    chk("sb_be", cap_be, 8'b0010);
    chk("sb_wdata", cap_wd, 64'h0000_AB00);
    run(1'b0, 3'b010, 9'h10, 64'h0, 64'h8081_8283, 4);
    chk("lw_wait_cycle", res_cycle, 5);
    chk("lw_wait_stall", stall_cnt, 5);
    chk("lw_wait_rdata", res_rd, 64'h8081_8283);
    chk("lw_wait_berr", res_berr, 1'b0);
    run(1'b0, 3'b001, 9'h12, 64'h0, 64'h8081_8283, 1);
    chk("lh_hi", res_rd, 64'hFFFF_8081);
    run(1'b0, 3'b101, 9'h12, 64'h0, 64'h8081_8283, 1);
    chk("lhu_hi", res_rd, 64'h8081);
    run(1'b0, 3'b001, 9'h10, 64'h0, 64'h0000_7283, 2);
    chk("lh_pos", res_rd, 64'h7283);
    run(1'b0, 3'b011, 9'h10, 64'h0, 64'h8081_8283, 1);
    chk("ld32_be", cap_be, 8'b1111);
    chk("ld32_rdata", res_rd, 64'h8081_8283);
    run(1'b0, 3'b010, 9'h10, 64'h0, 64'h1234_5678, -1);
    chk("to_cycle", res_cycle, 17);
    chk("to_berr", res_berr, 1'b1);
    chk("to_rdata", res_rd, 64'h0);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("late_ack_rv", o_rv, 1'b0);
    chk("late_ack_en", {o_re, o_we}, 2'b00);
    chk("idle_rdata", o_rd, 64'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_idle", {o_rdy, o_rv, o_berr}, 3'b100);
    run(1'b0, 3'b010, 9'h10, 64'h0, 64'h1234_5678, 16);
    chk("ack_at_max_cycle", res_cycle, 17);
    chk("ack_at_max_berr", res_berr, 1'b0);
    chk("ack_at_max_rdata", res_rd, 64'h1234_5678);
    run(1'b0, 3'b010, 9'h05, 64'h0, 64'hCAFE_F00D, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_cycle", res_cycle, 1);
    chk("mis_err", res_mis, 1'b1);
    chk("mis_no_en", saw_en, 1'b0);
    chk("mis_rdata", res_rd, 64'h0);
`else
    chk("mis_cycle", res_cycle, 2);
    chk("mis_err", res_mis, 1'b0);
    chk("mis_addr", cap_ma, 9'h04);
    chk("mis_rdata", res_rd, 64'hCAFE_F00D);
`endif
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 9'h10; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rst_mid_pre", o_re, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_en", {o_re, o_we}, 2'b00);
    chk("rst_mid_ready", o_rdy, 1'b1);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (o_rv) seen++;
      @(negedge clk);
    end
    chk("rst_mid_norsp", seen, 0);
    sel = 1'b1;
    run(1'b0, 3'b011, 9'h08, 64'h0, 64'h8000_0000_0000_0001, 1);
    chk("ld64_cycle", res_cycle, 2);
    chk("ld64_addr", cap_ma, 9'h08);
    chk("ld64_be", cap_be, 8'hFF);
    chk("ld64_rdata", res_rd, 64'h8000_0000_0000_0001);
    run(1'b1, 3'b011, 9'h10, 64'h1122_3344_5566_7788, 64'h0, 2);
    chk("sd64_we", {cap_re, cap_we}, 2'b01);
    chk("sd64_addr", cap_ma, 9'h10);
    chk("sd64_be", cap_be, 8'hFF);
    chk("sd64_wdata", cap_wd, 64'h1122_3344_5566_7788);
    run(1'b0, 3'b010, 9'h0C, 64'h0, 64'h8081_8283_8485_8687, 1);
    chk("lw64_addr", cap_ma, 9'h08);
    chk("lw64_be", cap_be, 8'hF0);
    chk("lw64_rdata", res_rd, 64'hFFFF_FFFF_8081_8283);
    run(1'b0, 3'b110, 9'h0C, 64'h0, 64'h8081_8283_8485_8687, 1);
    chk("lwu64_rdata", res_rd, 64'h0000_0000_8081_8283);
    run(1'b1, 3'b000, 9'h0F, 64'h5A, 64'h0, 1);
    chk("sb64_be", cap_be, 8'h80);
    chk("sb64_wdata", cap_wd, 64'h5A00_0000_0000_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
